writeback_stage: RTL and testbench

//  Final pipeline stage, directly downstream of the CSR stage. Selects the

---
 rtl/writeback_stage_pkg.sv | 29 ++
 rtl/writeback_stage_flush.sv | 83 ++++++++
 rtl/writeback_stage.sv | 117 +++++++++++
 tb/tb_writeback_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage.
//   CSR_*      : 3-bit command from the CSR stage
//   wb_sel_e   : 2-bit writeback source select
//   flush_st_e : redirect/flush FSM states
package writeback_stage_pkg;

  localparam logic [2:0] CSR_X     = 3'd0;
  localparam logic [2:0] CSR_W     = 3'd1;
  localparam logic [2:0] CSR_S     = 3'd2;
  localparam logic [2:0] CSR_C     = 3'd3;
  localparam logic [2:0] CSR_ECALL = 3'd4;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } flush_st_e;

  function automatic logic is_ecall(input logic [2:0] cmd);
    return cmd == CSR_ECALL;
  endfunction

endpackage

// File: rtl/writeback_stage_flush.sv
// Redirect/flush controller for the writeback stage.
//   state | meaning
//   RUN   | accepting instructions, no redirect in progress
//   FLUSH | redirect issued, wrong-path inputs dropped, hazard high
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   i_redirect     : accepted instruction redirects fetch this cycle
//   i_target       : redirect PC for that instruction
//   o_run          : FSM in RUN (instructions may be accepted)
//   o_hazard       : registered flush indication
//   o_target       : registered redirect PC
module wb_flush_ctrl
  import writeback_stage_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic        o_run,
  output logic        o_hazard,
  output logic [31:0] o_target
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  flush_st_e   r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_hazard, w_hazard_nxt;
  logic [31:0] r_target, w_target_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_hazard <= 1'b0;
      r_target <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hazard <= w_hazard_nxt;
      r_target <= w_target_nxt;
    end
  end

  // The counter loads FLUSH_CYCLES-1 on the redirect edge and the exit edge
  // happens at zero, so hazard spans exactly FLUSH_CYCLES cycles.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hazard_nxt = r_hazard;
    w_target_nxt = r_target;
    case (r_state)
      RUN: begin
        if (i_redirect) begin
          w_state_nxt  = FLUSH;
          w_cnt_nxt    = CNT_LOAD;
          w_hazard_nxt = 1'b1;
          w_target_nxt = i_target;
        end
      end
      FLUSH: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RUN;
          w_hazard_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt  = RUN;
        w_cnt_nxt    = '0;
        w_hazard_nxt = 1'b0;
      end
    endcase
  end

  assign o_run    = (r_state == RUN);
  assign o_hazard = r_hazard;
  assign o_target = r_target;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects and commits the register-file writeback value,
// resolves control flow (branch, jump, ECALL trap) and counts retired
// instructions. All outputs are registered.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_*                       : instruction fields from the CSR stage
//   csr_cmd/csr_rdata          : CSR command and read data
//   trap_vector                : mtvec
//   rf_wen/rf_waddr/rf_wdata   : register-file write port
//   wb_branch_hazard/_target   : fetch redirect and flush window
//   trap_valid/trap_epc        : ECALL commit pulse and its PC
//   instret                    : retired-instruction count
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_rf_wen,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_rdata,
  input  logic        in_br_flag,
  input  logic        in_jmp_flag,
  input  logic [31:0] in_br_target,
  input  logic [2:0]  csr_cmd,
  input  logic [31:0] csr_rdata,
  input  logic [31:0] trap_vector,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        wb_branch_hazard,
  output logic [31:0] wb_branch_target,
  output logic        trap_valid,
  output logic [31:0] trap_epc,
  output logic [63:0] instret
);

  logic        w_run;
  logic        w_accept;
  logic        w_ecall;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_wdata;
  logic        w_wen;

  logic        r_rf_wen;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;
  logic        r_trap_valid;
  logic [31:0] r_trap_epc;
  logic [63:0] r_instret;

  assign w_accept   = in_valid && w_run;
  assign w_ecall    = is_ecall(csr_cmd);
  assign w_redirect = w_accept && (w_ecall || in_jmp_flag || in_br_flag);
  // Jump and branch share in_br_target, so only ECALL changes the source.
  assign w_target   = w_ecall ? trap_vector : in_br_target;
  assign w_wen      = w_accept && in_rf_wen && (in_rd_addr != 5'd0) && !w_ecall;

  always_comb begin
    w_wdata = in_alu_out;
    case (wb_sel_e'(in_wb_sel))
      WB_ALU:  w_wdata = in_alu_out;
      WB_MEM:  w_wdata = in_mem_rdata;
      WB_PC4:  w_wdata = in_pc + 32'd4;
      WB_CSR:  w_wdata = csr_rdata;
      default: w_wdata = in_alu_out;
    endcase
  end

  wb_flush_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_redirect (w_redirect),
    .i_target   (w_target),
    .o_run      (w_run),
    .o_hazard   (wb_branch_hazard),
    .o_target   (wb_branch_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_wen     <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_trap_valid <= 1'b0;
      r_trap_epc   <= '0;
      r_instret    <= '0;
    end else begin
      r_rf_wen     <= w_wen;
      r_trap_valid <= w_accept && w_ecall;
      if (w_accept) begin
        r_rf_waddr <= in_rd_addr;
        r_rf_wdata <= w_wdata;
        r_instret  <= r_instret + 64'd1;
      end
      if (w_accept && w_ecall) begin
        r_trap_epc <= in_pc;
      end
    end
  end

  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign trap_valid = r_trap_valid;
  assign trap_epc   = r_trap_epc;
  assign instret    = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int unsigned FC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [4:0]  in_rd_addr;
  logic        in_rf_wen;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_out;
  logic [31:0] in_mem_rdata;
  logic        in_br_flag;
  logic        in_jmp_flag;
  logic [31:0] in_br_target;
  logic [2:0]  csr_cmd;
  logic [31:0] csr_rdata;
  logic [31:0] trap_vector;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_branch_hazard;
  logic [31:0] wb_branch_target;
  logic        trap_valid;
  logic [31:0] trap_epc;
  logic [63:0] instret;

  writeback_stage #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_rd_addr(in_rd_addr), .in_rf_wen(in_rf_wen), .in_wb_sel(in_wb_sel),
    .in_alu_out(in_alu_out), .in_mem_rdata(in_mem_rdata), .in_br_flag(in_br_flag),
    .in_jmp_flag(in_jmp_flag), .in_br_target(in_br_target), .csr_cmd(csr_cmd),
    .csr_rdata(csr_rdata), .trap_vector(trap_vector), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_branch_hazard(wb_branch_hazard),
    .wb_branch_target(wb_branch_target), .trap_valid(trap_valid),
    .trap_epc(trap_epc), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        br;
    logic        jmp;
    logic [31:0] tgt;
    logic [2:0]  cmd;
    logic [31:0] crd;
    logic [31:0] tvec;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hazard;
    logic [31:0] target;
    logic        trap;
    logic [31:0] epc;
    logic [63:0] instret;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Reference model state, written straight from the stage behaviour.
  int unsigned m_left    = 0;
  logic [63:0] m_instret = '0;
  logic [31:0] m_target  = '0;
  logic [31:0] m_epc     = '0;

  vec_t vecs[28];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rd, logic wen,
                              logic [1:0] sel, logic [31:0] alu, logic [31:0] mem,
                              logic br, logic jmp, logic [31:0] tgt, logic [2:0] cmd,
                              logic [31:0] crd, logic [31:0] tvec,
                              logic ew, logic [31:0] ewd);
    vec_t r;
    r.valid = v; r.pc = pc; r.rd = rd; r.wen = wen; r.sel = sel; r.alu = alu;
    r.mem = mem; r.br = br; r.jmp = jmp; r.tgt = tgt; r.cmd = cmd; r.crd = crd;
    r.tvec = tvec; r.exp_wen = ew; r.exp_wdata = ewd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.valid; in_pc = v.pc; in_rd_addr = v.rd; in_rf_wen = v.wen;
    in_wb_sel = v.sel; in_alu_out = v.alu; in_mem_rdata = v.mem;
    in_br_flag = v.br; in_jmp_flag = v.jmp; in_br_target = v.tgt;
    csr_cmd = v.cmd; csr_rdata = v.crd; trap_vector = v.tvec;
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    logic acc, ec, redir;
    @(negedge clk);
    drive(v);
    acc   = v.valid && (m_left == 0);
    ec    = (v.cmd == CSR_ECALL);
    redir = acc && (ec || v.br || v.jmp);
    if (acc) m_instret = m_instret + 64'd1;
    if (redir) begin
      m_left   = FC;
      m_target = ec ? v.tvec : v.tgt;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (acc && ec) m_epc = v.pc;
    e.wen = v.exp_wen; e.waddr = v.rd; e.wdata = v.exp_wdata;
    e.hazard = (m_left > 0); e.target = m_target;
    e.trap = acc && ec; e.epc = m_epc; e.instret = m_instret;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".rf_wen"}, 64'(rf_wen), 64'(e.wen));
    if (e.wen) begin
      chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(e.waddr));
      chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'(e.wdata));
    end
    chk({tag, ".hazard"}, 64'(wb_branch_hazard), 64'(e.hazard));
    if (e.hazard) chk({tag, ".target"}, 64'(wb_branch_target), 64'(e.target));
    chk({tag, ".trap_valid"}, 64'(trap_valid), 64'(e.trap));
    chk({tag, ".trap_epc"}, 64'(trap_epc), 64'(e.epc));
    chk({tag, ".instret"}, instret, e.instret);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rf_wen"}, 64'(rf_wen), 64'd0);
    chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, ".rf_wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, ".hazard"}, 64'(wb_branch_hazard), 64'd0);
    chk({tag, ".target"}, 64'(wb_branch_target), 64'd0);
    chk({tag, ".trap_valid"}, 64'(trap_valid), 64'd0);
    chk({tag, ".trap_epc"}, 64'(trap_epc), 64'd0);
    chk({tag, ".instret"}, instret, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t idle, drop;
    idle = mk(0, 0, 0, 0, WB_ALU, 0, 0, 0, 0, 0, CSR_X, 0, 0, 0, 0);
    drop = mk(1, 32'h10, 5'd2, 1, WB_ALU, 32'h55, 0, 0, 0, 0, CSR_X, 0, 0, 0, 0);

    vecs[0]  = mk(1, 32'h0, 5'd5, 1, WB_ALU, 32'h1234, 32'h9, 0, 0, 0, CSR_X, 32'h7, 0, 1, 32'h1234);
    vecs[1]  = mk(1, 32'h4, 5'd0, 1, WB_ALU, 32'hAAAA, 0, 0, 0, 0, CSR_X, 0, 0, 0, 0);
    vecs[2]  = mk(1, 32'h8, 5'd7, 1, WB_MEM, 32'h1, 32'hDEADBEEF, 0, 0, 0, CSR_X, 0, 0, 1, 32'hDEADBEEF);
    vecs[3]  = mk(1, 32'hC, 5'd3, 1, WB_CSR, 32'h1, 32'h2, 0, 0, 0, CSR_S, 32'hABC, 0, 1, 32'hABC);
    vecs[4]  = mk(1, 32'hFFFFFFFC, 5'd9, 1, WB_PC4, 32'h1, 0, 0, 0, 0, CSR_X, 0, 0, 1, 32'h0);
    vecs[5]  = idle;
    vecs[6]  = mk(1, 32'h14, 5'd4, 0, WB_ALU, 32'h77, 0, 0, 0, 0, CSR_X, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'h18, 5'd0, 0, WB_ALU, 0, 0, 1, 0, 32'h100, CSR_X, 0, 0, 0, 0);
    vecs[8]  = drop;
    vecs[9]  = drop;
    vecs[10] = drop;
    vecs[11] = mk(1, 32'h100, 5'd6, 1, WB_ALU, 32'h66, 0, 0, 0, 0, CSR_X, 0, 0, 1, 32'h66);
    vecs[12] = mk(1, 32'h80, 5'd8, 1, WB_ALU, 32'h88, 0, 0, 0, 0, CSR_ECALL, 0, 32'h200, 0, 0);
    vecs[13] = drop;
    vecs[14] = drop;
    vecs[15] = drop;
    vecs[16] = mk(1, 32'h40, 5'd1, 1, WB_PC4, 32'h5, 0, 0, 1, 32'h400, CSR_X, 0, 0, 1, 32'h44);
    vecs[17] = drop;
    vecs[18] = drop;
    vecs[19] = drop;
    vecs[20] = mk(1, 32'h90, 5'd0, 0, WB_ALU, 0, 0, 1, 1, 32'h999, CSR_ECALL, 0, 32'h300, 0, 0);
    vecs[21] = drop;
    vecs[22] = drop;
    vecs[23] = drop;
    vecs[24] = mk(1, 32'h94, 5'd0, 0, WB_ALU, 0, 0, 1, 1, 32'h500, CSR_X, 0, 0, 0, 0);
    vecs[25] = drop;
    vecs[26] = drop;
    vecs[27] = idle;

    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a flush window.
    apply(mk(1, 32'hA0, 5'd0, 0, WB_ALU, 0, 0, 1, 0, 32'h700, CSR_X, 0, 0, 0, 0), "rst_br");
    apply(drop, "rst_drop");
    @(negedge clk);
    drive(idle);
    rst_n = 1'b0;
    #1;
    check_zero("midflush_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_left = 0; m_instret = '0; m_target = '0; m_epc = '0;
    apply(mk(1, 32'hB0, 5'd10, 1, WB_ALU, 32'hBEEF, 0, 0, 0, 0, CSR_X, 0, 0, 1, 32'hBEEF), "post_rst0");
    apply(mk(1, 32'hB4, 5'd11, 1, WB_MEM, 0, 32'hCAFE, 0, 0, 0, CSR_X, 0, 0, 1, 32'hCAFE), "post_rst1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
